uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_byte_tx between N_REQ byte-stream requesters. Round-robin grant, held for a
//   whole packet (until req_last byte accepted or MAX_PKT bytes sent). Sits between the protocol
//   producers (command responder, debug/log streams) and the uart_byte_tx in_data/in_valid/ready port.
// PARAMETERS
//   N_REQ      4   number of requesters (2..8)
//   BYTE_SIZE  8   data width, must equal the uart_byte_tx BYTE_SIZE
//   MAX_PKT    16  max bytes per grant; grant is force-released after the MAX_PKT-th byte
// PORTS
//   CLK        in   1                single clock, all logic posedge
//   RST        in   1                synchronous, active-high reset
//   en         in   1                arbiter enable; low aborts the current grant
//   req_mask   in   N_REQ            per-requester permit; only masked-in requesters can win
//   req_valid  in   N_REQ            requester i has a byte on req_data[i]
//   req_data   in   N_REQ*BYTE_SIZE  flat bus, requester i at [i*BYTE_SIZE +: BYTE_SIZE]
//   req_last   in   N_REQ            byte on requester i is the final byte of its packet
//   req_ready  out  N_REQ            byte of requester i accepted this cycle when valid&ready
//   tx_data    out  BYTE_SIZE        to uart_byte_tx in_data
//   tx_valid   out  1                to uart_byte_tx in_valid
//   tx_ready   in   1                from uart_byte_tx ready
//   grant      out  N_REQ            one-hot current owner, 0 when idle
//   busy       out  1                a grant is held
//   pkt_done   out  1                1-cycle pulse: grant released normally (last or MAX_PKT)
//   pkt_abort  out  1                1-cycle pulse: grant dropped by en low
// BEHAVIOUR
//   Reset: state IDLE, grant=0, busy=0, pkt_done=0, pkt_abort=0, byte_cnt=0, rr_ptr=N_REQ-1
//     (requester 0 has top priority first); req_ready=0, tx_valid=0.
//   States: IDLE, XFER (2-bit encoding, leaves room for future states).
//   IDLE: cand = req_valid & req_mask. If en && cand!=0: choose first set bit searching
//     rr_ptr+1, rr_ptr+2, ... (mod N_REQ); register grant, rr_ptr<=winner, byte_cnt<=0, go XFER.
//     Grant appears the cycle after request: 1-cycle arbitration latency. No outputs asserted in IDLE.
//   XFER (owner g), purely combinational pass-through:
//     tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, req_ready[others]=0.
//     Accept = tx_valid && tx_ready; on accept byte_cnt++.
//     Release on accept when req_last[g] or byte_cnt==MAX_PKT-1: pkt_done=1 next cycle,
//     grant<=0, go IDLE. Hence one bubble cycle between packets (uart byte time dominates).
//   Owner dropping req_valid mid-packet: grant held, tx_valid=0, no timeout.
//   req_mask[g] deasserted mid-packet: ignored until release; mask only gates new wins.
//   en low in XFER: same cycle tx_valid=0, req_ready=0; next cycle IDLE, grant=0, pkt_abort=1,
//     rr_ptr kept (aborted owner goes to back of queue). en low in IDLE: no arbitration.
//   Simultaneous: release and new requests in same cycle -> new arbitration waits for IDLE cycle;
//     released owner may win again only if no other candidate is valid.
//   byte_cnt width $clog2(MAX_PKT+1); never wraps (release at MAX_PKT-1 resets it).
//   Reset mid-packet: all state to reset values next edge, no pkt_abort pulse.
//   tx_data is don't-care when tx_valid=0 (driven 0 for cleanliness).
// STRUCTURE
//   uart_defs.vh: state localparams (ST_IDLE, ST_XFER), shared with other uart controllers.
//   Sub-module rr_pick #(N): combinational; inputs req, ptr; outputs one-hot win, index, any.
//   Top: FSM, grant/rr_ptr/byte_cnt registers, output mux indexed by registered grant index.
// TESTING
//   1) Single req 0, packet 3 bytes A1,A2,A3 last on A3, tx_ready=1 -> grant=0001 cycle after
//      valid, 3 accepts, pkt_done pulse once, grant=0, busy=0.
//   2) Req 0 and 2 valid together, 2-byte packets each -> order 0,2,0,2 while both stay valid;
//      no byte of 2 interleaves inside packet of 0.
//   3) Req 1 streams 20 bytes with no last, MAX_PKT=16 -> release after 16th byte, pkt_done,
//      bytes 17-20 sent in a second grant (grant to 1 again if alone).
//   4) en dropped after 2nd byte of 4-byte packet -> tx_valid=0 same cycle, pkt_abort next cycle,
//      grant=0; en restored -> re-arbitration, next requester after aborted one wins first.
//   5) Owner drops req_valid 5 cycles mid-packet, req_mask[g] cleared -> grant held, resumes,
//      completes; masked requester then no longer wins.
//   6) tx_ready low 10 cycles with tx_valid=1 -> data stable, no accept, byte_cnt unchanged.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  // Two-bit encoding leaves room for future states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned base;
  int unsigned pos;

  always_comb begin
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    base = 32'(ptr);
    pos  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (base + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        win[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_byte_tx among N_REQ byte streams.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BYTE_SIZE = 8,
  parameter int unsigned MAX_PKT   = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req_mask,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BYTE_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [BYTE_SIZE-1:0]       tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       pkt_done,
  output logic                       pkt_abort
);

  localparam int unsigned   IW       = idx_w(N_REQ);
  localparam int unsigned   CW       = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 pkt_abort_q, pkt_abort_d;

  logic [N_REQ-1:0]     cand;
  logic [N_REQ-1:0]     pick_win;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [BYTE_SIZE-1:0] own_data;

  assign cand = req_valid & req_mask;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (cand),
    .ptr (rr_ptr_q),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    own_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx_q == IW'(i)) own_data = req_data[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    pkt_done_d  = 1'b0;
    pkt_abort_d = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (en && pick_any) begin
          state_d    = ST_XFER;
          grant_d    = pick_win;
          gidx_d     = pick_idx;
          rr_ptr_d   = pick_idx;
          byte_cnt_d = '0;
        end
      end

      ST_XFER: begin
        // rr_ptr already points at the aborted owner, so it drops to the back of the queue.
        if (!en) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          byte_cnt_d  = '0;
          pkt_abort_d = 1'b1;
        end else begin
          tx_valid          = req_valid[gidx_q];
          tx_data           = tx_valid ? own_data : '0;
          req_ready[gidx_q] = tx_ready;
          if (tx_valid && tx_ready) begin
            if (req_last[gidx_q] || byte_cnt_q == CNT_LAST) begin
              state_d    = ST_IDLE;
              grant_d    = '0;
              byte_cnt_d = '0;
              pkt_done_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= PTR_RST;
      byte_cnt_q  <= '0;
      pkt_done_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      pkt_done_q  <= pkt_done_d;
      pkt_abort_q <= pkt_abort_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == ST_XFER);
  assign pkt_done  = pkt_done_q;
  assign pkt_abort = pkt_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenario bench for uart_tx_arbiter with per-requester byte sources and an accept log.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BS = 8;
  localparam int MP = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic            en;
  logic [N-1:0]    req_mask;
  logic [N-1:0]    req_valid;
  logic [N*BS-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [BS-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            pkt_done;
  logic            pkt_abort;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .N_REQ     (N),
    .BYTE_SIZE (BS),
    .MAX_PKT   (MP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .req_mask  (req_mask),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_abort (pkt_abort)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] src_data [N][32];
  logic       src_last [N][32];
  int         src_len  [N];
  int         src_pos  [N];
  logic       hold     [N];

  int         log_req[$];
  logic [7:0] log_data[$];
  int         done_cnt, abort_cnt, done_at;

  logic [N-1:0]  s_grant, s_ready;
  logic          s_busy, s_tx_valid, s_done, s_abort;
  logic [BS-1:0] s_tx_data;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = !hold[i] && (src_pos[i] < src_len[i]);
      req_data[i*BS +: BS]  = src_data[i][src_pos[i]];
      req_last[i]           = src_last[i][src_pos[i]];
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      hold[i]    = 1'b0;
      for (int j = 0; j < 32; j++) begin
        src_data[i][j] = 8'h00;
        src_last[i][j] = 1'b0;
      end
    end
  endtask

  task automatic clear_log();
    log_req.delete();
    log_data.delete();
    done_cnt  = 0;
    abort_cnt = 0;
    done_at   = -1;
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_len[r]] = d;
    src_last[r][src_len[r]] = l;
    src_len[r]++;
    drive();
  endtask

  // One clock: sample at negedge, advance sources after the posedge.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge CLK);
    s_grant    = grant;
    s_busy     = busy;
    s_tx_valid = tx_valid;
    s_tx_data  = tx_data;
    s_ready    = req_ready;
    s_done     = pkt_done;
    s_abort    = pkt_abort;
    acc = '0;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) acc[i] = 1'b1;
    if (tx_valid && tx_ready) begin
      if (acc == '0) begin
        log_req.push_back(-1);
        log_data.push_back(tx_data);
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          log_req.push_back(i);
          log_data.push_back(tx_data);
        end
      end
    end
    if (pkt_done) begin
      done_cnt++;
      done_at = log_req.size();
    end
    if (pkt_abort) abort_cnt++;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
    drive();
  endtask

  task automatic apply_reset();
    clear_src();
    en       = 1'b1;
    req_mask = '1;
    tx_ready = 1'b1;
    drive();
    RST = 1'b1;
    cycle();
    cycle();
    RST = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    clear_src();
    en       = 1'b1;
    req_mask = '1;
    tx_ready = 1'b1;
    RST      = 1'b1;
    add_byte(0, 8'h55, 1'b1);
    cycle();
    cycle();
    checks++; if (s_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", s_grant); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    checks++; if (s_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", s_tx_valid); end
    checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", s_ready); end
    checks++; if (s_done !== 1'b0 || s_abort !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", s_done, s_abort); end
    checks++; if (dut.rr_ptr_q !== 2'd3) begin failures++; $display("FAIL reset_rr_ptr got=%0d exp=3", dut.rr_ptr_q); end
    checks++; if (dut.byte_cnt_q !== 5'd0) begin failures++; $display("FAIL reset_byte_cnt got=%0d exp=0", dut.byte_cnt_q); end
    clear_src();
    drive();
    RST = 1'b0;
    clear_log();
  endtask

  task automatic test_single();
    logic [7:0] ed [3];
    ed = '{8'hA1, 8'hA2, 8'hA3};
    add_byte(0, 8'hA1, 1'b0);
    add_byte(0, 8'hA2, 1'b0);
    add_byte(0, 8'hA3, 1'b1);
    cycle();
    checks++; if (s_grant !== 4'b0000) begin failures++; $display("FAIL single_latency got=%b exp=0000", s_grant); end
    cycle();
    checks++; if (s_grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", s_grant); end
    checks++; if (s_tx_valid !== 1'b1 || s_tx_data !== 8'hA1) begin failures++; $display("FAIL single_first got=%b/%02h exp=1/a1", s_tx_valid, s_tx_data); end
    checks++; if (s_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", s_ready); end
    cycle();
    cycle();
    cycle();
    checks++; if (s_done !== 1'b1 || s_grant !== 4'b0000 || s_busy !== 1'b0) begin failures++; $display("FAIL single_release got=done%b/grant%b/busy%b exp=1/0000/0", s_done, s_grant, s_busy); end
    cycle();
    checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", s_done); end
    checks++; if (done_cnt !== 1 || done_at !== 3) begin failures++; $display("FAIL single_done_count got=%0d@%0d exp=1@3", done_cnt, done_at); end
    checks++; if (log_req.size() !== 3) begin failures++; $display("FAIL single_log_len got=%0d exp=3", log_req.size()); end
    for (int k = 0; k < 3 && k < log_req.size(); k++) begin
      checks++; if (log_req[k] !== 0 || log_data[k] !== ed[k]) begin failures++; $display("FAIL single_log[%0d] got=%0d/%02h exp=0/%02h", k, log_req[k], log_data[k], ed[k]); end
    end
  endtask

  task automatic test_round_robin();
    int         er [8];
    logic [7:0] ed [8];
    er = '{0, 0, 2, 2, 0, 0, 2, 2};
    ed = '{8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hB2, 8'hB3, 8'hC2, 8'hC3};
    apply_reset();
    add_byte(0, 8'hB0, 1'b0); add_byte(0, 8'hB1, 1'b1);
    add_byte(0, 8'hB2, 1'b0); add_byte(0, 8'hB3, 1'b1);
    add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b1);
    add_byte(2, 8'hC2, 1'b0); add_byte(2, 8'hC3, 1'b1);
    for (int c = 0; c < 16; c++) cycle();
    checks++; if (done_cnt !== 4) begin failures++; $display("FAIL rr_done_count got=%0d exp=4", done_cnt); end
    checks++; if (log_req.size() !== 8) begin failures++; $display("FAIL rr_log_len got=%0d exp=8", log_req.size()); end
    for (int k = 0; k < 8 && k < log_req.size(); k++) begin
      checks++; if (log_req[k] !== er[k] || log_data[k] !== ed[k]) begin failures++; $display("FAIL rr_log[%0d] got=%0d/%02h exp=%0d/%02h", k, log_req[k], log_data[k], er[k], ed[k]); end
    end
  endtask

  task automatic test_max_pkt();
    apply_reset();
    for (int b = 0; b < 20; b++) add_byte(1, 8'(8'h10 + b), 1'b0);
    for (int c = 0; c < 30; c++) cycle();
    checks++; if (done_cnt !== 1 || done_at !== 16) begin failures++; $display("FAIL max_release got=%0d@%0d exp=1@16", done_cnt, done_at); end
    checks++; if (log_req.size() !== 20) begin failures++; $display("FAIL max_log_len got=%0d exp=20", log_req.size()); end
    for (int k = 0; k < 20 && k < log_req.size(); k++) begin
      checks++; if (log_req[k] !== 1 || log_data[k] !== 8'(8'h10 + k)) begin failures++; $display("FAIL max_log[%0d] got=%0d/%02h exp=1/%02h", k, log_req[k], log_data[k], 8'(8'h10 + k)); end
    end
    checks++; if (s_grant !== 4'b0010 || s_busy !== 1'b1) begin failures++; $display("FAIL max_regrant got=%b/%b exp=0010/1", s_grant, s_busy); end
    checks++; if (dut.byte_cnt_q !== 5'd4) begin failures++; $display("FAIL max_byte_cnt got=%0d exp=4", dut.byte_cnt_q); end
    RST = 1'b1;
    cycle();
    cycle();
    checks++; if (s_grant !== 4'b0000 || s_busy !== 1'b0) begin failures++; $display("FAIL midreset_state got=%b/%b exp=0000/0", s_grant, s_busy); end
    checks++; if (abort_cnt !== 0 || s_abort !== 1'b0) begin failures++; $display("FAIL midreset_abort got=%0d exp=0", abort_cnt); end
    clear_src();
    drive();
    RST = 1'b0;
  endtask

  task automatic test_abort();
    int         er [7];
    logic [7:0] ed [7];
    er = '{1, 1, 2, 2, 3, 1, 1};
    ed = '{8'hD0, 8'hD1, 8'hE0, 8'hE1, 8'hF0, 8'hD2, 8'hD3};
    apply_reset();
    add_byte(1, 8'hD0, 1'b0); add_byte(1, 8'hD1, 1'b0);
    add_byte(1, 8'hD2, 1'b0); add_byte(1, 8'hD3, 1'b1);
    cycle(); cycle(); cycle();
    en = 1'b0;
    add_byte(2, 8'hE0, 1'b0); add_byte(2, 8'hE1, 1'b1);
    add_byte(3, 8'hF0, 1'b1);
    cycle();
    checks++; if (s_tx_valid !== 1'b0 || s_ready !== 4'b0000) begin failures++; $display("FAIL abort_same_cycle got=%b/%b exp=0/0000", s_tx_valid, s_ready); end
    cycle();
    checks++; if (s_abort !== 1'b1 || s_grant !== 4'b0000 || s_busy !== 1'b0) begin failures++; $display("FAIL abort_pulse got=%b/%b/%b exp=1/0000/0", s_abort, s_grant, s_busy); end
    cycle();
    checks++; if (s_grant !== 4'b0000 || s_abort !== 1'b0) begin failures++; $display("FAIL abort_idle_hold got=%b/%b exp=0000/0", s_grant, s_abort); end
    en = 1'b1;
    for (int c = 0; c < 16; c++) cycle();
    checks++; if (abort_cnt !== 1 || done_cnt !== 3) begin failures++; $display("FAIL abort_counts got=%0d/%0d exp=1/3", abort_cnt, done_cnt); end
    checks++; if (log_req.size() !== 7) begin failures++; $display("FAIL abort_log_len got=%0d exp=7", log_req.size()); end
    for (int k = 0; k < 7 && k < log_req.size(); k++) begin
      checks++; if (log_req[k] !== er[k] || log_data[k] !== ed[k]) begin failures++; $display("FAIL abort_log[%0d] got=%0d/%02h exp=%0d/%02h", k, log_req[k], log_data[k], er[k], ed[k]); end
    end
  endtask

  task automatic test_hold_mask();
    int         er [5];
    logic [7:0] ed [5];
    er = '{0, 0, 0, 0, 3};
    ed = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70};
    apply_reset();
    add_byte(0, 8'h60, 1'b0); add_byte(0, 8'h61, 1'b0);
    add_byte(0, 8'h62, 1'b0); add_byte(0, 8'h63, 1'b1);
    cycle(); cycle(); cycle();
    hold[0]     = 1'b1;
    req_mask[0] = 1'b0;
    add_byte(3, 8'h70, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++; if (s_grant !== 4'b0001 || s_busy !== 1'b1 || s_tx_valid !== 1'b0) begin failures++; $display("FAIL hold_cycle%0d got=%b/%b/%b exp=0001/1/0", c, s_grant, s_busy, s_tx_valid); end
    end
    hold[0] = 1'b0;
    add_byte(0, 8'h64, 1'b1);
    for (int c = 0; c < 12; c++) cycle();
    checks++; if (log_req.size() !== 5) begin failures++; $display("FAIL hold_log_len got=%0d exp=5", log_req.size()); end
    for (int k = 0; k < 5 && k < log_req.size(); k++) begin
      checks++; if (log_req[k] !== er[k] || log_data[k] !== ed[k]) begin failures++; $display("FAIL hold_log[%0d] got=%0d/%02h exp=%0d/%02h", k, log_req[k], log_data[k], er[k], ed[k]); end
    end
    checks++; if (s_grant !== 4'b0000 || s_busy !== 1'b0 || src_pos[0] !== 4) begin failures++; $display("FAIL mask_blocks got=%b/%b/%0d exp=0000/0/4", s_grant, s_busy, src_pos[0]); end
  endtask

  task automatic test_stall();
    apply_reset();
    tx_ready = 1'b0;
    add_byte(2, 8'h9A, 1'b0);
    add_byte(2, 8'h9B, 1'b1);
    cycle();
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++; if (s_tx_valid !== 1'b1 || s_tx_data !== 8'h9A || s_ready !== 4'b0000 || dut.byte_cnt_q !== 5'd0) begin failures++; $display("FAIL stall_cycle%0d got=%b/%02h/%b/%0d exp=1/9a/0000/0", c, s_tx_valid, s_tx_data, s_ready, dut.byte_cnt_q); end
    end
    checks++; if (log_req.size() !== 0) begin failures++; $display("FAIL stall_no_accept got=%0d exp=0", log_req.size()); end
    tx_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    checks++; if (log_req.size() !== 2 || done_cnt !== 1) begin failures++; $display("FAIL stall_resume got=%0d/%0d exp=2/1", log_req.size(), done_cnt); end
    for (int k = 0; k < 2 && k < log_req.size(); k++) begin
      checks++; if (log_req[k] !== 2 || log_data[k] !== 8'(8'h9A + k)) begin failures++; $display("FAIL stall_log[%0d] got=%0d/%02h exp=2/%02h", k, log_req[k], log_data[k], 8'(8'h9A + k)); end
    end
  endtask

  initial begin
    RST       = 1'b1;
    en        = 1'b1;
    req_mask  = '1;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_log();
    test_reset();
    test_single();
    test_round_robin();
    test_max_pkt();
    test_abort();
    test_hold_mask();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
